mult_div_unit: RTL

Iterative multiply/divide unit with HI/LO registers for the five-stage MIPS pipeline. It executes MULT, MULTU, DIV and DIVU as a radix-2 shift-add or restoring engine, one bit per cycle. It sits beside the EX-stage ALU, and Busy is fed to hazard detection to stall MFHI/MFLO and back-to-back mult/div ops. Operand width is parametrised, and the unit supports cancellation by a pipeline flush.

---
 rtl/mult_div_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative radix-2 multiply/divide unit (MULT/MULTU/DIV/DIVU)
//            with architectural HI/LO registers, one bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             Cancel,
    input  logic             WriteHI,
    input  logic             WriteLO,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_count_init = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_count_one  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dbz_pend;
    logic             r_done;
    logic             r_dbz;

    // Operand conditioning at launch: Op[0]=0 selects the signed variants
    logic             w_signed;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_div_zero;
    logic             w_launch;

    assign w_signed   = ~Op[0];
    assign w_sign_a   = w_signed & OperandA[WIDTH-1];
    assign w_sign_b   = w_signed & OperandB[WIDTH-1];
    assign w_mag_a    = w_sign_a ? -OperandA : OperandA;
    assign w_mag_b    = w_sign_b ? -OperandB : OperandB;
    assign w_div_zero = Op[1] & ~|OperandB;
    assign w_launch   = (r_state == S_IDLE) & Start & ~Cancel;

    // Shift-add multiply step: {r_acc, r_q} shifts right, multiplier drains from r_q
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH-1:0] w_mul_q;

    assign w_add     = {1'b0, r_acc} + {1'b0, r_b};
    assign w_mul_sum = r_q[0] ? w_add : {1'b0, r_acc};
    assign w_mul_acc = w_mul_sum[WIDTH:1];
    assign w_mul_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};

    // Restoring divide step; remainder < divisor keeps the trial difference
    // within WIDTH+1 bits, so its top bit is a borrow flag
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_div_acc;
    logic [WIDTH-1:0] w_div_q;

    assign w_shift   = {r_acc, r_q[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_b};
    assign w_fits    = ~w_diff[WIDTH];
    assign w_div_acc = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_div_q   = {r_q[WIDTH-2:0], w_fits};

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quot     = r_neg_q ? -r_q : r_q;
    assign w_rem      = r_neg_r ? -r_acc : r_acc;
    assign w_res_hi   = r_is_div ? w_rem  : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo   = r_is_div ? w_quot : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start && !Cancel) begin
                    w_state_next = w_div_zero ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (Cancel) begin
                    w_state_next = S_IDLE;
                end else if (r_count == c_count_one) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (WriteHI) begin
                        r_hi <= WriteData;
                    end
                    if (WriteLO) begin
                        r_lo <= WriteData;
                    end
                    if (w_launch) begin
                        r_acc      <= '0;
                        r_q        <= w_mag_a;
                        r_b        <= w_mag_b;
                        r_count    <= w_div_zero ? '0 : c_count_init;
                        r_is_div   <= Op[1];
                        r_neg_q    <= w_sign_a ^ w_sign_b;
                        r_neg_r    <= w_sign_a;
                        r_dbz_pend <= w_div_zero;
                    end
                end
                S_RUN: begin
                    if (Cancel) begin
                        r_count <= '0;
                    end else begin
                        r_count <= r_count - c_count_one;
                        r_acc   <= r_is_div ? w_div_acc : w_mul_acc;
                        r_q     <= r_is_div ? w_div_q   : w_mul_q;
                    end
                end
                S_FIX: begin
                    if (!Cancel) begin
                        r_done <= 1'b1;
                        if (r_dbz_pend) begin
                            r_dbz <= 1'b1;
                        end else begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    assign Busy      = (r_state != S_IDLE);
    assign Done      = r_done;
    assign DivByZero = r_dbz;
    assign HI        = r_hi;
    assign LO        = r_lo;

endmodule
`default_nettype wire
